// File: rtl/exec_pkg.sv
// Shared constants for the exec_core slice:
// instruction kinds, phase bit indices and IR field positions.
package exec_pkg;

    localparam logic [9:0] KIND_ADD  = 10'h000;
    localparam logic [9:0] KIND_SUB  = 10'h001;
    localparam logic [9:0] KIND_AND  = 10'h002;
    localparam logic [9:0] KIND_OR   = 10'h003;
    localparam logic [9:0] KIND_XOR  = 10'h004;
    localparam logic [9:0] KIND_SLL  = 10'h005;
    localparam logic [9:0] KIND_SRL  = 10'h006;
    localparam logic [9:0] KIND_SRA  = 10'h007;
    localparam logic [9:0] KIND_MOV  = 10'h008;
    localparam logic [9:0] KIND_ADDI = 10'h100;
    localparam logic [9:0] KIND_LI   = 10'h101;
    localparam logic [9:0] KIND_LUI  = 10'h102;
    localparam logic [9:0] KIND_SLLI = 10'h103;
    localparam logic [9:0] KIND_ST   = 10'h22C;
    localparam logic [9:0] KIND_LD   = 10'h22D;
    localparam logic [9:0] KIND_B    = 10'h300;
    localparam logic [9:0] KIND_BEQ  = 10'h301;
    localparam logic [9:0] KIND_BNE  = 10'h302;
    localparam logic [9:0] KIND_BLT  = 10'h303;
    localparam logic [9:0] KIND_JR   = 10'h310;
    localparam logic [9:0] KIND_HLT  = 10'h3FF;

    localparam int PH_FETCH = 0;
    localparam int PH_DEC   = 1;
    localparam int PH_EX    = 2;
    localparam int PH_MEM   = 3;
    localparam int PH_WB    = 4;

    localparam int IR_KIND_HI = 31;
    localparam int IR_KIND_LO = 22;
    localparam int IR_RA1_HI  = 21;
    localparam int IR_RA1_LO  = 19;
    localparam int IR_RA2_HI  = 18;
    localparam int IR_RA2_LO  = 16;
    localparam int IR_IM16_HI = 15;
    localparam int IR_SIM8_HI = 7;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational result and branch-taken evaluation
// for every instruction kind; unknown kinds yield zero.
module exec_alu
    import exec_pkg::*;
(
    input  logic [9:0]  kind,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [7:0]  sim8,
    input  logic [15:0] im16,
    input  logic [31:0] p,
    output logic [31:0] result,
    output logic        taken
);

    logic [31:0] br_target;
    logic [31:0] mem_addr;

    assign br_target = p + sext16(im16);
    assign mem_addr  = rd2 + sext16(im16);

    // select result and taken flag by instruction kind
    always_comb begin
        result = '0;
        taken  = 1'b0;
        case (kind)
            KIND_ADD:  result = rd2 + rd1;
            KIND_SUB:  result = rd2 - rd1;
            KIND_AND:  result = rd2 & rd1;
            KIND_OR:   result = rd2 | rd1;
            KIND_XOR:  result = rd2 ^ rd1;
            KIND_SLL:  result = rd2 << rd1[4:0];
            KIND_SRL:  result = rd2 >> rd1[4:0];
            KIND_SRA:  result = 32'($signed(rd2) >>> rd1[4:0]);
            KIND_MOV:  result = rd1;
            KIND_ADDI: result = rd2 + sext8(sim8);
            KIND_LI:   result = sext16(im16);
            KIND_LUI:  result = {im16, 16'h0000};
            KIND_SLLI: result = rd2 << sim8[4:0];
            KIND_LD:   result = mem_addr;
            KIND_ST:   result = mem_addr;
            KIND_B: begin
                result = br_target;
                taken  = 1'b1;
            end
            KIND_BEQ: begin
                result = br_target;
                taken  = (rd1 == rd2);
            end
            KIND_BNE: begin
                result = br_target;
                taken  = (rd1 != rd2);
            end
            KIND_BLT: begin
                result = br_target;
                taken  = ($signed(rd2) < $signed(rd1));
            end
            KIND_JR: begin
                result = rd2;
                taken  = 1'b1;
            end
            default: begin
                result = '0;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exec_core.sv
// Decode/execute/sequencing core: IR, decoder, PC,
// registered ALU result and halt latch for a 5-phase CPU.
module exec_core
    import exec_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [4:0]  phase,
    input  logic [31:0] q,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic [2:0]  ra1,
    output logic [2:0]  ra2,
    output logic [2:0]  wba,
    output logic [31:0] wb,
    output logic        r_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    output logic [31:0] p,
    output logic [31:0] z,
    output logic        ct_taken,
    output logic        hlt
);

    logic [31:0] ir;
    logic [9:0]  kind;
    logic [15:0] im16;
    logic [7:0]  sim8;
    logic [31:0] alu_result;
    logic        alu_taken;
    logic        is_alu;
    logic        is_imm;
    logic        is_ld;
    logic        is_st;
    logic        unused_fetch;

    assign kind = ir[IR_KIND_HI:IR_KIND_LO];
    assign ra1  = ir[IR_RA1_HI:IR_RA1_LO];
    assign ra2  = ir[IR_RA2_HI:IR_RA2_LO];
    assign im16 = ir[IR_IM16_HI:0];
    assign sim8 = ir[IR_SIM8_HI:0];

    // fetch needs no core action: m_addr already shows p
    assign unused_fetch = phase[PH_FETCH];

    assign is_alu = (kind <= KIND_MOV);
    assign is_imm = (kind >= KIND_ADDI) && (kind <= KIND_SLLI);
    assign is_ld  = (kind == KIND_LD);
    assign is_st  = (kind == KIND_ST);

    exec_alu u_alu (
        .kind   (kind),
        .rd1    (rd1),
        .rd2    (rd2),
        .sim8   (sim8),
        .im16   (im16),
        .p      (p),
        .result (alu_result),
        .taken  (alu_taken)
    );

    assign m_addr  = phase[PH_MEM] ? z : p;
    assign m_wdata = rd1;
    assign m_we    = phase[PH_MEM] & is_st;
    assign r_we    = phase[PH_WB] & (is_alu | is_imm | is_ld);
    assign wb      = is_ld ? q : z;
    assign wba     = is_ld ? ra1 : ra2;

    // instruction register captures RAM word in decode
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ir <= '0;
        end else if (phase[PH_DEC]) begin
            ir <= q;
        end
    end

    // execute registers ALU result and branch decision
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            z        <= '0;
            ct_taken <= 1'b0;
        end else if (phase[PH_EX]) begin
            z        <= alu_result;
            ct_taken <= alu_taken;
        end
    end

    // writeback advances PC and latches a halt request
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p   <= RESET_PC;
            hlt <= 1'b0;
        end else if (phase[PH_WB]) begin
            p <= ct_taken ? z : p + 32'd4;
            if (kind == KIND_HLT) begin
                hlt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core: directed scenarios
// plus random instructions against a behavioural model.
module tb_exec_core;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [4:0]  phase;
    logic [31:0] q;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  wba;
    logic [31:0] wb;
    logic        r_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] p;
    logic [31:0] z;
    logic        ct_taken;
    logic        hlt;

    int passed = 0;
    int total  = 0;
    logic [31:0] p_m;
    logic        hlt_m;

    typedef struct packed {
        logic [31:0] fetch_addr;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [31:0] z;
        logic        ct;
        logic [31:0] mem_addr;
        logic        mem_we;
        logic [31:0] wdata;
        logic        r_we;
        logic [2:0]  wba;
        logic [31:0] wb;
        logic [31:0] p_after;
        logic        hlt;
        logic        we_other;
    } obs_t;

    exec_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .phase    (phase),
        .q        (q),
        .rd1      (rd1),
        .rd2      (rd2),
        .ra1      (ra1),
        .ra2      (ra2),
        .wba      (wba),
        .wb       (wb),
        .r_we     (r_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_we     (m_we),
        .p        (p),
        .z        (z),
        .ct_taken (ct_taken),
        .hlt      (hlt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [9:0] k,
                                        input logic [2:0] a1,
                                        input logic [2:0] a2,
                                        input logic [15:0] im);
        return {k, a1, a2, im};
    endfunction

    // Behavioural reference: what one instruction should do.
    function automatic void model(input logic [31:0] ir,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] pc,
                                  output logic [31:0] ez,
                                  output logic et,
                                  output logic erw,
                                  output logic emw);
        logic [9:0]  k;
        logic [31:0] s16;
        logic [31:0] s8;
        int          sh;
        k   = ir[31:22];
        s16 = {{16{ir[15]}}, ir[15:0]};
        s8  = {{24{ir[7]}}, ir[7:0]};
        sh  = int'(a[4:0]);
        ez  = 32'd0;
        et  = 1'b0;
        erw = 1'b0;
        emw = 1'b0;
        case (k)
            10'h000: begin ez = b + a; erw = 1'b1; end
            10'h001: begin ez = b - a; erw = 1'b1; end
            10'h002: begin ez = b & a; erw = 1'b1; end
            10'h003: begin ez = b | a; erw = 1'b1; end
            10'h004: begin ez = b ^ a; erw = 1'b1; end
            10'h005: begin ez = b << sh; erw = 1'b1; end
            10'h006: begin ez = b >> sh; erw = 1'b1; end
            10'h007: begin
                ez = (b >> sh) |
                     (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                erw = 1'b1;
            end
            10'h008: begin ez = a; erw = 1'b1; end
            10'h100: begin ez = b + s8; erw = 1'b1; end
            10'h101: begin ez = s16; erw = 1'b1; end
            10'h102: begin ez = {ir[15:0], 16'd0}; erw = 1'b1; end
            10'h103: begin ez = b << int'(ir[4:0]); erw = 1'b1; end
            10'h22D: begin ez = b + s16; erw = 1'b1; end
            10'h22C: begin ez = b + s16; emw = 1'b1; end
            10'h300: begin ez = pc + s16; et = 1'b1; end
            10'h301: begin ez = pc + s16; et = (a == b); end
            10'h302: begin ez = pc + s16; et = (a != b); end
            10'h303: begin
                ez = pc + s16;
                et = ($signed(b) < $signed(a));
            end
            10'h310: begin ez = b; et = 1'b1; end
            default: ez = 32'd0;
        endcase
    endfunction

    // Drive one instruction through all five phases and record outputs.
    task automatic run_instr(input logic [31:0] ir,
                             input logic [31:0] a,
                             input logic [31:0] b,
                             input logic [31:0] ld,
                             output obs_t o);
        o = '0;
        @(negedge clk);
        phase = 5'b00001; q = ir; rd1 = a; rd2 = b;
        #1;
        o.fetch_addr = m_addr;
        o.we_other = m_we | r_we;
        @(negedge clk);
        phase = 5'b00010;
        #1;
        o.we_other |= m_we | r_we;
        @(negedge clk);
        phase = 5'b00100;
        #1;
        o.ra1 = ra1;
        o.ra2 = ra2;
        o.we_other |= m_we | r_we;
        @(negedge clk);
        phase = 5'b01000;
        #1;
        o.z = z;
        o.ct = ct_taken;
        o.mem_addr = m_addr;
        o.mem_we = m_we;
        o.wdata = m_wdata;
        o.we_other |= r_we;
        q = ld;
        @(negedge clk);
        phase = 5'b10000;
        #1;
        o.r_we = r_we;
        o.wba = wba;
        o.wb = wb;
        o.we_other |= m_we;
        @(negedge clk);
        phase = 5'b00000;
        #1;
        o.p_after = p;
        o.hlt = hlt;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; phase = 5'b0; q = '0; rd1 = '0; rd2 = '0;
        repeat (3) @(negedge clk);
        total++; if (p !== 32'd0) $display("FAIL rst_p got %h exp %h", p, 32'd0); else passed++;
        total++; if (z !== 32'd0) $display("FAIL rst_z got %h exp %h", z, 32'd0); else passed++;
        total++; if (ct_taken !== 1'b0) $display("FAIL rst_ct got %b exp 0", ct_taken); else passed++;
        total++; if (hlt !== 1'b0) $display("FAIL rst_hlt got %b exp 0", hlt); else passed++;
        total++; if (r_we !== 1'b0) $display("FAIL rst_rwe got %b exp 0", r_we); else passed++;
        total++; if (m_we !== 1'b0) $display("FAIL rst_mwe got %b exp 0", m_we); else passed++;
        n_rst = 1'b1;
        @(negedge clk);
        phase = 5'b00001;
        #1;
        total++; if (m_addr !== 32'd0) $display("FAIL rst_fetch got %h exp %h", m_addr, 32'd0); else passed++;
        @(negedge clk);
        phase = 5'b00000;
        p_m = 32'd0;
        hlt_m = 1'b0;
    endtask

    task automatic test_li();
        obs_t o;
        run_instr(enc(10'h101, 3'd0, 3'd2, 16'd5), 32'd0, 32'd0, 32'd0, o);
        total++; if (o.r_we !== 1'b1) $display("FAIL li_rwe got %b exp 1", o.r_we); else passed++;
        total++; if (o.wba !== 3'd2) $display("FAIL li_wba got %0d exp 2", o.wba); else passed++;
        total++; if (o.wb !== 32'd5) $display("FAIL li_wb got %h exp %h", o.wb, 32'd5); else passed++;
        total++; if (o.p_after !== p_m + 32'd4) $display("FAIL li_p got %h exp %h", o.p_after, p_m + 32'd4); else passed++;
        p_m = p_m + 32'd4;
    endtask

    task automatic test_add_sub();
        obs_t o;
        run_instr(enc(10'h000, 3'd1, 3'd2, 16'd0), 32'd7, 32'hFFFF_FFFE, 32'd0, o);
        total++; if (o.z !== 32'd5) $display("FAIL add_z got %h exp %h", o.z, 32'd5); else passed++;
        total++; if (o.wba !== 3'd2) $display("FAIL add_wba got %0d exp 2", o.wba); else passed++;
        total++; if (o.ra1 !== 3'd1) $display("FAIL add_ra1 got %0d exp 1", o.ra1); else passed++;
        p_m = p_m + 32'd4;
        run_instr(enc(10'h001, 3'd1, 3'd2, 16'd0), 32'd7, 32'hFFFF_FFFE, 32'd0, o);
        total++; if (o.z !== 32'hFFFF_FFF7) $display("FAIL sub_z got %h exp %h", o.z, 32'hFFFF_FFF7); else passed++;
        p_m = p_m + 32'd4;
    endtask

    task automatic test_ld();
        obs_t o;
        run_instr(32'h8B5A_0008, 32'd0, 32'h100, 32'h1234_5678, o);
        total++; if (o.mem_addr !== 32'h108) $display("FAIL ld_addr got %h exp %h", o.mem_addr, 32'h108); else passed++;
        total++; if (o.wb !== 32'h1234_5678) $display("FAIL ld_wb got %h exp %h", o.wb, 32'h1234_5678); else passed++;
        total++; if (o.wba !== 3'd3) $display("FAIL ld_wba got %0d exp 3", o.wba); else passed++;
        total++; if (o.r_we !== 1'b1) $display("FAIL ld_rwe got %b exp 1", o.r_we); else passed++;
        total++; if (o.mem_we !== 1'b0) $display("FAIL ld_mwe got %b exp 0", o.mem_we); else passed++;
        p_m = p_m + 32'd4;
    endtask

    task automatic test_st();
        obs_t o;
        run_instr(enc(10'h22C, 3'd1, 3'd2, 16'd4), 32'hDEAD_BEEF, 32'h40, 32'd0, o);
        total++; if (o.mem_we !== 1'b1) $display("FAIL st_mwe got %b exp 1", o.mem_we); else passed++;
        total++; if (o.we_other !== 1'b0) $display("FAIL st_we_other got %b exp 0", o.we_other); else passed++;
        total++; if (o.mem_addr !== 32'h44) $display("FAIL st_addr got %h exp %h", o.mem_addr, 32'h44); else passed++;
        total++; if (o.wdata !== 32'hDEAD_BEEF) $display("FAIL st_wdata got %h exp %h", o.wdata, 32'hDEAD_BEEF); else passed++;
        total++; if (o.r_we !== 1'b0) $display("FAIL st_rwe got %b exp 0", o.r_we); else passed++;
        p_m = p_m + 32'd4;
    endtask

    task automatic test_branch();
        obs_t o;
        run_instr(enc(10'h310, 3'd0, 3'd1, 16'd0), 32'd0, 32'h20, 32'd0, o);
        total++; if (o.p_after !== 32'h20) $display("FAIL jr_p got %h exp %h", o.p_after, 32'h20); else passed++;
        p_m = 32'h20;
        run_instr(enc(10'h301, 3'd1, 3'd2, 16'hFFF0), 32'd9, 32'd9, 32'd0, o);
        total++; if (o.ct !== 1'b1) $display("FAIL beq_ct got %b exp 1", o.ct); else passed++;
        total++; if (o.p_after !== 32'h10) $display("FAIL beq_p got %h exp %h", o.p_after, 32'h10); else passed++;
        total++; if (o.r_we !== 1'b0) $display("FAIL beq_rwe got %b exp 0", o.r_we); else passed++;
        p_m = 32'h10;
        run_instr(enc(10'h310, 3'd0, 3'd1, 16'd0), 32'd0, 32'h20, 32'd0, o);
        p_m = 32'h20;
        run_instr(enc(10'h302, 3'd1, 3'd2, 16'hFFF0), 32'd9, 32'd9, 32'd0, o);
        total++; if (o.ct !== 1'b0) $display("FAIL bne_ct got %b exp 0", o.ct); else passed++;
        total++; if (o.p_after !== 32'h24) $display("FAIL bne_p got %h exp %h", o.p_after, 32'h24); else passed++;
        p_m = 32'h24;
        run_instr(enc(10'h303, 3'd1, 3'd2, 16'h0010), 32'd1, 32'hFFFF_FFFF, 32'd0, o);
        total++; if (o.p_after !== 32'h34) $display("FAIL blt_p got %h exp %h", o.p_after, 32'h34); else passed++;
        p_m = 32'h34;
    endtask

    task automatic test_wrap();
        obs_t o;
        run_instr(enc(10'h310, 3'd0, 3'd1, 16'd0), 32'd0, 32'hFFFF_FFFC, 32'd0, o);
        p_m = 32'hFFFF_FFFC;
        run_instr(enc(10'h3AA, 3'd5, 3'd6, 16'h1234), 32'd3, 32'd4, 32'd0, o);
        total++; if (o.p_after !== 32'd0) $display("FAIL wrap_p got %h exp %h", o.p_after, 32'd0); else passed++;
        total++; if (o.z !== 32'd0) $display("FAIL nop_z got %h exp %h", o.z, 32'd0); else passed++;
        total++; if (o.r_we !== 1'b0) $display("FAIL nop_rwe got %b exp 0", o.r_we); else passed++;
        p_m = 32'd0;
    endtask

    task automatic test_random();
        logic [9:0] kinds [21] = '{
            10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
            10'h006, 10'h007, 10'h008, 10'h100, 10'h101, 10'h102,
            10'h103, 10'h22D, 10'h22C, 10'h300, 10'h301, 10'h302,
            10'h303, 10'h310, 10'h3FF
        };
        obs_t        o;
        logic [9:0]  k;
        logic [31:0] ir, a, b, ld, ez, ewb, ep;
        logic        et, erw, emw;
        logic [2:0]  ewba;
        int          errs;
        for (int i = 0; i < 150; i++) begin
            k = kinds[$urandom_range(0, 20)];
            if ($urandom_range(0, 9) == 0) k = 10'($urandom_range(16'h3C0, 16'h3FE));
            ir = {k, 22'($urandom)};
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            ld = $urandom;
            model(ir, a, b, p_m, ez, et, erw, emw);
            ewb = (k == 10'h22D) ? ld : ez;
            ewba = (k == 10'h22D) ? ir[21:19] : ir[18:16];
            ep = et ? ez : p_m + 32'd4;
            if (k == 10'h3FF) hlt_m = 1'b1;
            run_instr(ir, a, b, ld, o);
            errs = 0;
            total++; if (o.fetch_addr !== p_m) begin $display("FAIL rnd_fetch got %h exp %h", o.fetch_addr, p_m); errs++; end else passed++;
            total++; if (o.ra1 !== ir[21:19] || o.ra2 !== ir[18:16]) begin $display("FAIL rnd_ra got %0d/%0d exp %0d/%0d", o.ra1, o.ra2, ir[21:19], ir[18:16]); errs++; end else passed++;
            total++; if (o.z !== ez) begin $display("FAIL rnd_z ir %h got %h exp %h", ir, o.z, ez); errs++; end else passed++;
            total++; if (o.ct !== et) begin $display("FAIL rnd_ct ir %h got %b exp %b", ir, o.ct, et); errs++; end else passed++;
            total++; if (o.mem_addr !== ez || o.mem_we !== emw) begin $display("FAIL rnd_mem ir %h got %h/%b exp %h/%b", ir, o.mem_addr, o.mem_we, ez, emw); errs++; end else passed++;
            total++; if (o.wdata !== a) begin $display("FAIL rnd_wdata got %h exp %h", o.wdata, a); errs++; end else passed++;
            total++; if (o.r_we !== erw) begin $display("FAIL rnd_rwe ir %h got %b exp %b", ir, o.r_we, erw); errs++; end else passed++;
            total++; if (erw && (o.wb !== ewb || o.wba !== ewba)) begin $display("FAIL rnd_wb ir %h got %h@%0d exp %h@%0d", ir, o.wb, o.wba, ewb, ewba); errs++; end else passed++;
            total++; if (o.we_other !== 1'b0) begin $display("FAIL rnd_we_other ir %h got 1 exp 0", ir); errs++; end else passed++;
            total++; if (o.p_after !== ep) begin $display("FAIL rnd_p ir %h got %h exp %h", ir, o.p_after, ep); errs++; end else passed++;
            total++; if (o.hlt !== hlt_m) begin $display("FAIL rnd_hlt ir %h got %b exp %b", ir, o.hlt, hlt_m); errs++; end else passed++;
            p_m = ep;
            if (errs > 0) break;
        end
    endtask

    task automatic test_halt();
        obs_t o;
        run_instr(enc(10'h3FF, 3'd0, 3'd0, 16'd0), 32'd0, 32'd0, 32'd0, o);
        total++; if (o.hlt !== 1'b1) $display("FAIL hlt_set got %b exp 1", o.hlt); else passed++;
        total++; if (o.r_we !== 1'b0) $display("FAIL hlt_rwe got %b exp 0", o.r_we); else passed++;
        run_instr(enc(10'h101, 3'd0, 3'd1, 16'd1), 32'd0, 32'd0, 32'd0, o);
        total++; if (o.hlt !== 1'b1) $display("FAIL hlt_sticky got %b exp 1", o.hlt); else passed++;
        hlt_m = 1'b1;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge clk);
        phase = 5'b00001; q = enc(10'h101, 3'd3, 3'd4, 16'h1234);
        @(negedge clk);
        phase = 5'b00010;
        @(negedge clk);
        phase = 5'b00100;
        @(negedge clk);
        phase = 5'b01000;
        #1;
        total++; if (z !== 32'h1234) $display("FAIL mid_z_pre got %h exp %h", z, 32'h1234); else passed++;
        n_rst = 1'b0;
        #1;
        total++; if (z !== 32'd0) $display("FAIL mid_z got %h exp %h", z, 32'd0); else passed++;
        total++; if (p !== 32'd0) $display("FAIL mid_p got %h exp %h", p, 32'd0); else passed++;
        total++; if (hlt !== 1'b0) $display("FAIL mid_hlt got %b exp 0", hlt); else passed++;
        total++; if (ra1 !== 3'd0 || ra2 !== 3'd0) $display("FAIL mid_ir got %0d/%0d exp 0/0", ra1, ra2); else passed++;
        @(negedge clk);
        phase = 5'b00000;
        @(negedge clk);
        n_rst = 1'b1;
        p_m = 32'd0;
        hlt_m = 1'b0;
        run_instr(enc(10'h102, 3'd0, 3'd5, 16'hABCD), 32'd0, 32'd0, 32'd0, o);
        total++; if (o.wb !== 32'hABCD_0000) $display("FAIL mid_lui got %h exp %h", o.wb, 32'hABCD_0000); else passed++;
        total++; if (o.p_after !== 32'd4) $display("FAIL mid_p_after got %h exp %h", o.p_after, 32'd4); else passed++;
    endtask

    initial begin
        test_reset();
        test_li();
        test_add_sub();
        test_ld();
        test_st();
        test_branch();
        test_wrap();
        test_random();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
